// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared pipeline constants for hazard, forwarding and control blocks
package hazard_scoreboard_pkg;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int LONG_LAT_DEF = 4;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LONG_BUSY = 1'b1;
  typedef logic [REG_W-1:0] regIdx_t;
endpackage

// File: rtl/hazard_scoreboard_long_timer.sv
// long_op_timer: latency counter for the in-flight multicycle op, strobes done on its final cycle
module long_op_timer
  import hazard_scoreboard_pkg::*;
#(
  parameter int LONG_LAT = LONG_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic busy,
  output logic done
);
  logic [CNT_W-1:0] count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (start) count <= CNT_W'(LONG_LAT);
    else if (busy) count <= count - 1'b1;
  assign done = busy & (count == CNT_W'(1));
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: load-use and multicycle-op hazard detection with stall/flush control
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int LONG_LAT = LONG_LAT_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         IfIdValid,
  input  regIdx_t      IfIdRegRs,
  input  regIdx_t      IfIdRegRt,
  input  logic         IfIdUsesRt,
  input  logic         IfIdRegWrite,
  input  regIdx_t      IfIdRegRd,
  input  logic         IfIdLong,
  input  logic         IdExMemRead,
  input  regIdx_t      IdExRegRt,
  input  logic         BranchTaken,
  output logic         PcWrite,
  output logic         IfIdWrite,
  output logic         IdExBubble,
  output logic         IfIdFlush,
  output logic         LongDone,
  output regIdx_t      LongRd,
  output logic [15:0]  StallCount
);
  logic [0:0] state;
  logic loadUse, longHaz, stall, start, busy;
  assign busy = state == LONG_BUSY;
  assign loadUse = IfIdValid & IdExMemRead & (IdExRegRt != '0) &
                   ((IdExRegRt == IfIdRegRs) | (IfIdUsesRt & (IdExRegRt == IfIdRegRt)));
  // A second long op is a structural hazard; register matches cover RAW and WAW on LongRd.
  assign longHaz = busy & IfIdValid & (IfIdLong | ((LongRd != '0) &
                   ((LongRd == IfIdRegRs) | (IfIdUsesRt & (LongRd == IfIdRegRt)) |
                    (IfIdRegWrite & (LongRd == IfIdRegRd)))));
  assign stall = (loadUse | longHaz) & ~BranchTaken;
  assign start = ~busy & IfIdValid & IfIdLong & ~stall & ~BranchTaken;
  assign PcWrite = ~stall;
  assign IfIdWrite = ~stall;
  assign IdExBubble = stall | BranchTaken;
  assign IfIdFlush = BranchTaken;
  long_op_timer #(.LONG_LAT(LONG_LAT)) timer (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .busy (busy),
    .done (LongDone)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      LongRd <= '0;
      StallCount <= '0;
    end else begin
      if (start) state <= LONG_BUSY;
      else if (LongDone) state <= IDLE;
      if (start) LongRd <= IfIdRegWrite ? IfIdRegRd : '0;
      if (stall && StallCount != 16'hFFFF) StallCount <= StallCount + 1'b1;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: vector table plus multicycle sequences, checked through an expectation queue
module tb_hazard_scoreboard;
  typedef struct {
    string name;
    logic valid, isLong, regWrite, usesRt;
    logic [4:0] rs, rt, rd;
    logic memRead;
    logic [4:0] exRt;
    logic br;
    logic stall, flush, done;
    logic [4:0] lrd;
  } vec_t;

  logic clk = 0, rst_n = 0;
  logic IfIdValid = 0, IfIdUsesRt = 0, IfIdRegWrite = 0, IfIdLong = 0, IdExMemRead = 0, BranchTaken = 0;
  logic [4:0] IfIdRegRs = 0, IfIdRegRt = 0, IfIdRegRd = 0, IdExRegRt = 0;
  logic PcWrite, IfIdWrite, IdExBubble, IfIdFlush, LongDone;
  logic [4:0] LongRd;
  logic [15:0] StallCount;
  int applied = 0, miscompares = 0;
  logic [15:0] expStall = 0;
  logic [4:0] curRd = 0;
  vec_t expQ[$];
  vec_t tbl[11];

  hazard_scoreboard #(.LONG_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .IfIdValid(IfIdValid), .IfIdRegRs(IfIdRegRs), .IfIdRegRt(IfIdRegRt),
    .IfIdUsesRt(IfIdUsesRt), .IfIdRegWrite(IfIdRegWrite), .IfIdRegRd(IfIdRegRd), .IfIdLong(IfIdLong),
    .IdExMemRead(IdExMemRead), .IdExRegRt(IdExRegRt), .BranchTaken(BranchTaken), .PcWrite(PcWrite),
    .IfIdWrite(IfIdWrite), .IdExBubble(IdExBubble), .IfIdFlush(IfIdFlush), .LongDone(LongDone),
    .LongRd(LongRd), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(string n, logic v, logic lg, logic rw, logic urt, logic [4:0] rs, logic [4:0] rt,
                              logic [4:0] rd, logic mr, logic [4:0] ert, logic br, logic st, logic fl,
                              logic dn, logic [4:0] lrd);
    vec_t x;
    x.name = n; x.valid = v; x.isLong = lg; x.regWrite = rw; x.usesRt = urt;
    x.rs = rs; x.rt = rt; x.rd = rd; x.memRead = mr; x.exRt = ert; x.br = br;
    x.stall = st; x.flush = fl; x.done = dn; x.lrd = lrd;
    return x;
  endfunction

  function automatic vec_t idle(string n, logic dn, logic [4:0] lrd);
    return mk(n, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, dn, lrd);
  endfunction

  task automatic check();
    vec_t e;
    logic ok;
    e = expQ.pop_front();
    applied++;
    ok = PcWrite === ~e.stall && IfIdWrite === ~e.stall && IdExBubble === (e.stall | e.flush) &&
         IfIdFlush === e.flush && LongDone === e.done && LongRd === e.lrd && StallCount === expStall;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got pc=%b ifw=%b bub=%b fl=%b done=%b rd=%0d cnt=%0d, want pc=%b ifw=%b bub=%b fl=%b done=%b rd=%0d cnt=%0d",
               e.name, PcWrite, IfIdWrite, IdExBubble, IfIdFlush, LongDone, LongRd, StallCount,
               ~e.stall, ~e.stall, e.stall | e.flush, e.flush, e.done, e.lrd, expStall);
    end
    if (e.stall) expStall++;
  endtask

  task automatic apply(input vec_t v);
    IfIdValid = v.valid; IfIdLong = v.isLong; IfIdRegWrite = v.regWrite; IfIdUsesRt = v.usesRt;
    IfIdRegRs = v.rs; IfIdRegRt = v.rt; IfIdRegRd = v.rd; IdExMemRead = v.memRead;
    IdExRegRt = v.exRt; BranchTaken = v.br;
    expQ.push_back(v);
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = idle("idle", 0, 0);
    tbl[1]  = mk("loadUseRs", 1, 0, 0, 0, 5, 0, 0, 1, 5, 0, 1, 0, 0, 0);
    tbl[2]  = idle("afterLoadUse", 0, 0);
    tbl[3]  = mk("r0NoStall", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk("loadUseRt", 1, 0, 0, 1, 3, 7, 0, 1, 7, 0, 1, 0, 0, 0);
    tbl[5]  = mk("rtUnused", 1, 0, 0, 0, 3, 7, 0, 1, 7, 0, 0, 0, 0, 0);
    tbl[6]  = mk("invalidId", 0, 0, 0, 1, 7, 7, 0, 1, 7, 0, 0, 0, 0, 0);
    tbl[7]  = mk("noLoad", 1, 0, 0, 1, 7, 7, 0, 0, 7, 0, 0, 0, 0, 0);
    tbl[8]  = mk("branchOverStall", 1, 0, 0, 0, 5, 0, 0, 1, 5, 1, 0, 1, 0, 0);
    tbl[9]  = mk("branchOnly", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    tbl[10] = mk("rdNotLoadUse", 1, 0, 1, 0, 1, 2, 5, 1, 5, 0, 0, 0, 0, 0);
    #1;
    apply(idle("reset0", 0, 0));
    apply(idle("reset1", 0, 0));
    rst_n = 1;
    foreach (tbl[i]) apply(tbl[i]);
    // dependent on a long op stalls through the LongDone cycle and issues right after
    apply(mk("longIssue8", 1, 1, 1, 0, 0, 0, 8, 0, 0, 0, 0, 0, 0, curRd));
    for (int i = 0; i < 4; i++) apply(mk("depOnR8", 1, 0, 0, 0, 8, 0, 0, 0, 0, 0, 1, 0, i == 3, 8));
    apply(mk("depIssues", 1, 0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 8));
    curRd = 8;
    // structural hazard: second long op waits, then issues; branch leaves in-flight op alone
    apply(mk("longIssue9", 1, 1, 1, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0, curRd));
    for (int i = 0; i < 4; i++) apply(mk("secondLongWait", 1, 1, 1, 0, 0, 0, 10, 0, 0, 0, 1, 0, i == 3, 9));
    apply(mk("secondLongIssue", 1, 1, 1, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0, 9));
    for (int i = 0; i < 4; i++)
      apply(mk("drain10", 0, 0, 0, 0, 0, 0, 0, 0, 0, i == 1, 0, i == 1, i == 3, 10));
    apply(idle("afterDrain10", 0, 10));
    // a long op without a destination tracks r0 and never creates a register hazard
    apply(mk("longNoWrite", 1, 1, 0, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 10));
    apply(mk("r0NoLongHaz", 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(idle("drain0a", 0, 0));
    apply(idle("drain0b", 0, 0));
    apply(idle("drain0c", 1, 0));
    apply(mk("longIssue12", 1, 1, 1, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0));
    apply(mk("wawStall", 1, 0, 1, 0, 1, 2, 12, 0, 0, 0, 1, 0, 0, 12));
    apply(mk("invalidNoHaz", 0, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 12));
    apply(idle("drain12a", 0, 12));
    apply(idle("drain12b", 1, 12));
    // reset in the second busy cycle abandons the op
    apply(mk("longIssue3", 1, 1, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 12));
    apply(idle("busy1", 0, 3));
    rst_n = 0;
    expStall = 0;
    apply(idle("resetMidOp", 0, 0));
    rst_n = 1;
    for (int i = 0; i < 6; i++) apply(idle("noLateDone", 0, 0));
    apply(mk("loadUsePostReset", 1, 0, 0, 0, 9, 0, 0, 1, 9, 0, 1, 0, 0, 0));
    apply(idle("final", 0, 0));
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
